// File: rtl/transpose_buffer_if.sv
// Bus between the 2-D DCT control/datapath and the 8x8 transpose buffer.
// master = control side, slave = buffer side.
interface transpose_buffer_if #(
   parameter int W = 16
);
   localparam int N = 8;

   logic           enable_write;
   logic           enable_read;
   logic           direction;
   logic [2:0]     counter;
   logic [N*W-1:0] din;
   logic [N*W-1:0] dout;
   logic           dout_valid;

   modport master (
      output enable_write,
      output enable_read,
      output direction,
      output counter,
      output din,
      input  dout,
      input  dout_valid
   );

   modport slave (
      input  enable_write,
      input  enable_read,
      input  direction,
      input  counter,
      input  din,
      output dout,
      output dout_valid
   );
endinterface

// File: rtl/transpose_buffer.sv
// 8x8 transpose memory between the H and V 1-D DCT2 passes.
// Define TRANSPOSE_OUT_REG_EN for a second output register stage (latency 2).
module transpose_buffer #(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   transpose_buffer_if.slave   bus
);
   localparam int N = 8;

   logic [W-1:0]   mem_q [N][N];
   logic [W-1:0]   mem_d [N][N];
   logic [N*W-1:0] rd_row;
   logic [N*W-1:0] rd_col;
   logic [N*W-1:0] dout_d;
   logic [N*W-1:0] dout_q;
   logic           dout_valid_d;
   logic           dout_valid_q;

   always_comb begin
      rd_row = '0;
      rd_col = '0;
      for (int k = 0; k < N; k++) begin
         rd_row[k*W +: W] = mem_q[bus.counter][k];
         rd_col[k*W +: W] = mem_q[k][bus.counter];
      end
   end

   // Reads see mem_q, so a same-cycle write is visible only from the next read.
   always_comb begin
      mem_d = mem_q;
      if (bus.enable_write) begin
         for (int k = 0; k < N; k++) begin
            mem_d[bus.counter][k] = bus.din[k*W +: W];
         end
      end
   end

   always_comb begin
      dout_d = dout_q;
      if (bus.enable_read) begin
         dout_d = bus.direction ? rd_row : rd_col;
      end
      dout_valid_d = bus.enable_read & ~bus.direction;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               mem_q[r][c] <= '0;
            end
         end
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

`ifdef TRANSPOSE_OUT_REG_EN
   logic           rd_d;
   logic           rd_q;
   logic [N*W-1:0] dout2_d;
   logic [N*W-1:0] dout2_q;
   logic           dout_valid2_d;
   logic           dout_valid2_q;

   // Stage 2 only reloads when stage 1 took a read, so both stages hold.
   always_comb begin
      rd_d          = bus.enable_read;
      dout2_d       = rd_q ? dout_q : dout2_q;
      dout_valid2_d = dout_valid_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q          <= 1'b0;
         dout2_q       <= '0;
         dout_valid2_q <= 1'b0;
      end else begin
         rd_q          <= rd_d;
         dout2_q       <= dout2_d;
         dout_valid2_q <= dout_valid2_d;
      end
   end

   assign bus.dout       = dout2_q;
   assign bus.dout_valid = dout_valid2_q;
`else
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
`endif
endmodule
